halftone_diffuser: RTL and testbench



---
 rtl/halftone_diffuser.sv | 149 ++++++++++++++
 tb/tb_halftone_diffuser.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/halftone_diffuser.sv
// Streaming Floyd-Steinberg halftoner: 8-bit gray in, 1-bit halftone out, one frame per start.
// Define HALFTONE_DIFFUSION_EN for error diffusion; otherwise a plain threshold is applied.
module halftone_diffuser #(
  parameter int unsigned WIDTH     = 64,
  parameter int unsigned HEIGHT    = 64,
  parameter int unsigned THRESHOLD = 128
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_gray,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       out_bit,
  output logic       out_eol,
  output logic       out_eof,
  output logic       frame_done,
  output logic       busy
);

  localparam int unsigned XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int unsigned YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] ACTIVE = 2'd1;
  localparam logic [1:0] DRAIN  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          out_valid_q, out_bit_q, out_eol_q, out_eof_q, frame_done_q;
  logic          in_hs, out_hs, x_last, y_last, bit_d;

  assign out_valid  = out_valid_q;
  assign out_bit    = out_bit_q;
  assign out_eol    = out_eol_q;
  assign out_eof    = out_eof_q;
  assign frame_done = frame_done_q;
  assign busy       = (state_q == ACTIVE) || (state_q == DRAIN);
  assign in_ready   = (state_q == ACTIVE) && (!out_valid_q || out_ready);
  assign in_hs      = in_valid && in_ready;
  assign out_hs     = out_valid_q && out_ready;
  assign x_last     = (x_q == XW'(WIDTH - 1));
  assign y_last     = (y_q == YW'(HEIGHT - 1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = ACTIVE;
      ACTIVE:  if (in_hs && x_last && y_last) state_d = DRAIN;
      DRAIN:   if (out_hs) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      x_q          <= '0;
      y_q          <= '0;
      out_valid_q  <= 1'b0;
      out_bit_q    <= 1'b0;
      out_eol_q    <= 1'b0;
      out_eof_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      // Only the final pixel is outstanding in DRAIN, so its handshake ends the frame.
      frame_done_q <= (state_q == DRAIN) && out_hs;
      if (state_q == IDLE && start) begin
        x_q <= '0;
        y_q <= '0;
      end else if (in_hs) begin
        if (x_last) begin
          x_q <= '0;
          y_q <= y_last ? '0 : y_q + YW'(1);
        end else begin
          x_q <= x_q + XW'(1);
        end
      end
      if (in_hs) begin
        out_valid_q <= 1'b1;
        out_bit_q   <= bit_d;
        out_eol_q   <= x_last;
        out_eof_q   <= x_last && y_last;
      end else if (out_hs) begin
        out_valid_q <= 1'b0;
      end
    end
  end

`ifdef HALFTONE_DIFFUSION_EN
  logic signed [10:0] line_buf [WIDTH];
  logic signed [10:0] carry_q, pend0_q, pend1_q;
  logic signed [11:0] below, carry_in, v, e;
  logic signed [10:0] s7, s5, s3, s1;

  function automatic logic signed [10:0] share(input logic signed [11:0] err,
                                               input logic [3:0] w);
    logic signed [15:0] p;
    logic signed [15:0] q;
    p = $signed({{4{err[11]}}, err}) * $signed({12'b0, w});
    q = p >>> 4;
    return q[10:0];
  endfunction

  always_comb begin
    below    = (y_q == '0) ? 12'sd0 : {line_buf[x_q][10], line_buf[x_q]};
    carry_in = (x_q == '0) ? 12'sd0 : {carry_q[10], carry_q};
    v        = $signed({4'b0, in_gray}) + carry_in + below;
    bit_d    = (v >= $signed(12'(THRESHOLD)));
    e        = bit_d ? v - 12'sd255 : v;
    s7       = share(e, 4'd7);
    s5       = share(e, 4'd5);
    s3       = share(e, 4'd3);
    s1       = share(e, 4'd1);
  end

  // pend0 accumulates next-row entry x-1, pend1 entry x; an entry is written once complete,
  // which is always after the current row has read it.
  always_ff @(posedge clk) begin
    if (in_hs && !y_last) begin
      if (x_q != '0) line_buf[x_q - XW'(1)] <= pend0_q + s3;
      if (x_last)    line_buf[x_q]          <= pend1_q + s5;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      carry_q <= '0;
      pend0_q <= '0;
      pend1_q <= '0;
    end else if (state_q == IDLE && start) begin
      carry_q <= '0;
      pend0_q <= '0;
      pend1_q <= '0;
    end else if (in_hs) begin
      carry_q <= x_last ? 11'sd0 : s7;
      pend0_q <= ((x_q == '0) ? 11'sd0 : pend1_q) + s5;
      pend1_q <= s1;
    end
  end
`else
  assign bit_d = ({1'b0, in_gray} >= 9'(THRESHOLD));
`endif

endmodule

// File: tb/tb_halftone_diffuser.sv
// Directed bench for halftone_diffuser on a 4x2 frame; expected bits hand-computed per build.
module tb_halftone_diffuser;

  localparam int W = 4;
  localparam int H = 2;

`ifdef HALFTONE_DIFFUSION_EN
  localparam logic [7:0] EXP100 = 8'b1010_0010;  // 0,1,0,0 / 0,1,0,1
  localparam logic [7:0] EXP128 = 8'b1010_0101;  // 1,0,1,0 / 0,1,0,1
`else
  localparam logic [7:0] EXP100 = 8'h00;
  localparam logic [7:0] EXP128 = 8'hFF;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic       out_ready = 1'b1;
  logic [7:0] in_gray = 8'h00;
  logic       in_ready, out_valid, out_bit, out_eol, out_eof, frame_done, busy;

  int n_tests = 0;
  int n_fail = 0;
  int fd_count = 0;

  logic [7:0] p0 [8];
  logic [7:0] pff [8];
  logic [7:0] p100 [8];
  logic [7:0] p128 [8];

  halftone_diffuser #(.WIDTH(W), .HEIGHT(H), .THRESHOLD(128)) dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
    .in_gray(in_gray), .out_valid(out_valid), .out_ready(out_ready), .out_bit(out_bit),
    .out_eol(out_eol), .out_eof(out_eof), .frame_done(frame_done), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (frame_done === 1'b1) fd_count++;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts a frame, streams it, and checks every output; stall_at < 0 means no stall.
  task automatic run_frame(input logic [7:0] pix [8], input logic [7:0] exp_bits,
                           input int stall_at);
    int in_idx = 0;
    int out_idx = 0;
    int cycles = 0;
    int stall_cnt = 0;
    logic hb = 1'b0, he = 1'b0, hf = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    while (out_idx < 8 && cycles < 200) begin
      in_valid  = (in_idx < 8);
      in_gray   = (in_idx < 8) ? pix[in_idx] : 8'h00;
      out_ready = !(out_idx == stall_at && stall_cnt < 3);
      #1;
      check_eq("busy", busy, 1);
      if (out_valid && !out_ready) begin
        if (stall_cnt > 0) begin
          check_eq("stall_bit", out_bit, hb);
          check_eq("stall_eol", out_eol, he);
          check_eq("stall_eof", out_eof, hf);
        end
        check_eq("stall_in_ready", in_ready, 0);
        hb = out_bit; he = out_eol; hf = out_eof;
        stall_cnt++;
      end
      if (out_valid && out_ready) begin
        check_eq($sformatf("out_bit[%0d]", out_idx), out_bit, exp_bits[out_idx]);
        check_eq($sformatf("out_eol[%0d]", out_idx), out_eol, (out_idx % W) == W - 1);
        check_eq($sformatf("out_eof[%0d]", out_idx), out_eof, out_idx == 7);
        out_idx++;
      end
      if (in_valid && in_ready) in_idx++;
      cycles++;
      @(negedge clk);
    end
    if (out_idx < 8) check_eq("timeout", out_idx, 8);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    check_eq("frame_done", frame_done, 1);
    check_eq("busy_after", busy, 0);
    check_eq("out_valid_after", out_valid, 0);
  endtask

  initial begin
    foreach (p0[i]) begin
      p0[i] = 8'd0; pff[i] = 8'd255; p100[i] = 8'd100; p128[i] = 8'd128;
    end

    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_in_ready", in_ready, 0);
    check_eq("rst_out_valid", out_valid, 0);
    check_eq("rst_out_bit", out_bit, 0);
    check_eq("rst_out_eol", out_eol, 0);
    check_eq("rst_out_eof", out_eof, 0);
    check_eq("rst_frame_done", frame_done, 0);
    check_eq("rst_busy", busy, 0);
    @(negedge clk);
    rst = 1'b0;

    in_valid = 1'b1;
    in_gray  = 8'd200;
    repeat (4) begin
      @(negedge clk);
      #1;
      check_eq("idle_in_ready", in_ready, 0);
      check_eq("idle_out_valid", out_valid, 0);
      check_eq("idle_busy", busy, 0);
    end
    in_valid = 1'b0;
    @(negedge clk);

    run_frame(p0, 8'h00, -1);
    run_frame(pff, 8'hFF, -1);
    @(negedge clk);
    #1;
    check_eq("frame_done_single", frame_done, 0);
    check_eq("fd_count_2", fd_count, 2);

    // Second frame starts in the frame_done cycle of the first.
    run_frame(p100, EXP100, -1);
    run_frame(p100, EXP100, -1);

    run_frame(p128, EXP128, 2);

    // Reset partway through a frame, then a clean run must match.
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    in_valid = 1'b1;
    in_gray  = 8'd128;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("midrst_out_valid", out_valid, 0);
    check_eq("midrst_busy", busy, 0);
    check_eq("midrst_in_ready", in_ready, 0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    run_frame(p128, EXP128, -1);

    @(negedge clk);
    check_eq("fd_count_total", fd_count, 6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
